// File: rtl/axis_block_bridge_pkg.sv
// Shared types and helpers for the byte-stream <-> block bridge.
//   pad_mode_e   : padding policy applied to a partial block on idle timeout
//   pack_state_e : packer FSM states
//   slot_lsb()   : bit offset of a byte slot inside a block, honouring the
//                  byte-order setting; both directions use it so the packer
//                  and serializer can never disagree on ordering.
package axis_block_bridge_pkg;

    typedef enum logic [1:0] {
        PAD_NONE  = 2'd0,
        PAD_ZERO  = 2'd1,
        PAD_COUNT = 2'd2
    } pad_mode_e;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        HOLD = 2'd2
    } pack_state_e;

    // Slot 0 is the first byte on the wire. With msb_first it lands in the
    // top byte lane of the block, otherwise in bits [7:0].
    function automatic int slot_lsb(input int slot, input int nbytes, input bit msb_first);
        return msb_first ? 8 * (nbytes - 1 - slot) : 8 * slot;
    endfunction

endpackage

// File: rtl/axis_block_bridge_serializer.sv
// block_serializer: unpacks one cipher block into a byte stream with tlast.
//   clk, rst          : clock, async active-high reset
//   s_blk_*           : incoming block (AXI-Stream, 8*BLOCK_BYTES wide)
//   m_byte_*          : outgoing bytes, tlast on the final byte of each block
// A new block is accepted in the same cycle the last byte of the current one
// is taken, so consecutive blocks stream without a bubble.
module block_serializer
    import axis_block_bridge_pkg::*;
#(
    parameter int BLOCK_BYTES = 8,
    parameter int MSB_FIRST   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [8*BLOCK_BYTES-1:0] s_blk_tdata,
    input  logic                     s_blk_tvalid,
    output logic                     s_blk_tready,
    output logic [7:0]               m_byte_tdata,
    output logic                     m_byte_tvalid,
    input  logic                     m_byte_tready,
    output logic                     m_byte_tlast
);

    localparam int             IW   = $clog2(BLOCK_BYTES);
    localparam int             DW   = 8 * BLOCK_BYTES;
    localparam logic [IW-1:0]  LAST = IW'(BLOCK_BYTES - 1);
    localparam bit             MSB  = (MSB_FIRST != 0);

    logic [DW-1:0] sreg;
    logic [IW-1:0] cnt;
    logic          full;
    logic          run;   // low while in reset and on the first edge after it
    logic          load;
    logic          take;

    assign m_byte_tvalid = full;
    assign m_byte_tlast  = full && (cnt == LAST);
    assign m_byte_tdata  = sreg[slot_lsb(int'(cnt), BLOCK_BYTES, MSB) +: 8];
    assign s_blk_tready  = run && (!full || (m_byte_tlast && m_byte_tready));

    assign load = s_blk_tvalid && s_blk_tready;
    assign take = full && m_byte_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
            full <= 1'b0;
            run  <= 1'b0;
        end else begin
            run <= 1'b1;
            // A load always coincides with either empty or the final take.
            if (load) begin
                sreg <= s_blk_tdata;
                cnt  <= '0;
                full <= 1'b1;
            end else if (take) begin
                if (cnt == LAST) begin
                    full <= 1'b0;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + IW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/axis_block_bridge.sv
// axis_block_bridge: byte-stream <-> cipher-block bridge.
//   clk, rst      : clock, async active-high reset
//   s_byte_*      : UART RX bytes into the packer
//   m_blk_*       : packed blocks to the cipher; tuser=1 marks a padded block
//   s_blk_*       : blocks from the cipher into the serializer
//   m_byte_*      : UART TX bytes, tlast on the last byte of each block
//   blk_count     : blocks delivered on m_blk (wrapping)
//   pad_pulse     : one-cycle pulse when a partial block starts padding
// The packer FSM lives here; the serializer is a separate instance and the
// two directions share only clock and reset.
module axis_block_bridge
    import axis_block_bridge_pkg::*;
#(
    parameter int BLOCK_BYTES    = 8,
    parameter int MSB_FIRST      = 1,
    parameter int PAD_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               s_byte_tdata,
    input  logic                     s_byte_tvalid,
    output logic                     s_byte_tready,
    output logic [8*BLOCK_BYTES-1:0] m_blk_tdata,
    output logic                     m_blk_tvalid,
    input  logic                     m_blk_tready,
    output logic                     m_blk_tuser,
    input  logic [8*BLOCK_BYTES-1:0] s_blk_tdata,
    input  logic                     s_blk_tvalid,
    output logic                     s_blk_tready,
    output logic [7:0]               m_byte_tdata,
    output logic                     m_byte_tvalid,
    input  logic                     m_byte_tready,
    output logic                     m_byte_tlast,
    output logic [15:0]              blk_count,
    output logic                     pad_pulse
);

    localparam int            IW     = $clog2(BLOCK_BYTES);
    localparam int            TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int            TW     = (TW_RAW < 1) ? 1 : TW_RAW;
    localparam int            DW     = 8 * BLOCK_BYTES;
    localparam logic [IW-1:0] LAST   = IW'(BLOCK_BYTES - 1);
    localparam logic [1:0]    MODE_B = PAD_MODE[1:0];
    localparam pad_mode_e     MODE   = pad_mode_e'(MODE_B);
    localparam bit            TO_EN  = (MODE != PAD_NONE) && (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] T_EXP  = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit            MSB    = (MSB_FIRST != 0);

    pack_state_e   state;
    logic [IW-1:0] idx;
    logic [TW-1:0] timer;
    logic [7:0]    pad_val;
    logic [DW-1:0] blk;
    logic          tuser;
    logic          run;     // holds s_byte_tready low until the first edge out of reset
    logic          accept;
    logic          expire;

    assign s_byte_tready = run && (state == FILL);
    assign accept        = s_byte_tvalid && s_byte_tready;
    // An accept in the expiry cycle takes priority: the block is still filling.
    assign expire        = TO_EN && (state == FILL) && (idx != '0) && !accept && (timer == T_EXP);

    assign m_blk_tdata   = blk;
    assign m_blk_tvalid  = (state == HOLD);
    assign m_blk_tuser   = tuser;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            idx       <= '0;
            timer     <= '0;
            pad_val   <= '0;
            blk       <= '0;
            tuser     <= 1'b0;
            blk_count <= '0;
            pad_pulse <= 1'b0;
            run       <= 1'b0;
        end else begin
            run       <= 1'b1;
            pad_pulse <= 1'b0;
            case (state)
                FILL: begin
                    if (accept) begin
                        blk[slot_lsb(int'(idx), BLOCK_BYTES, MSB) +: 8] <= s_byte_tdata;
                        timer <= '0;
                        if (idx == LAST) begin
                            state <= HOLD;
                            tuser <= 1'b0;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end else if (expire) begin
                        state     <= PAD;
                        pad_pulse <= 1'b1;
                        timer     <= '0;
                        pad_val   <= (MODE == PAD_COUNT) ? 8'(BLOCK_BYTES - int'(idx)) : 8'h00;
                    end else if (TO_EN && idx != '0) begin
                        timer <= timer + TW'(1);
                    end
                end
                PAD: begin
                    blk[slot_lsb(int'(idx), BLOCK_BYTES, MSB) +: 8] <= pad_val;
                    if (idx == LAST) begin
                        state <= HOLD;
                        tuser <= 1'b1;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                HOLD: begin
                    if (m_blk_tready) begin
                        blk_count <= blk_count + 16'd1;
                        idx       <= '0;
                        tuser     <= 1'b0;
                        state     <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    block_serializer #(
        .BLOCK_BYTES (BLOCK_BYTES),
        .MSB_FIRST   (MSB_FIRST)
    ) u_ser (
        .clk           (clk),
        .rst           (rst),
        .s_blk_tdata   (s_blk_tdata),
        .s_blk_tvalid  (s_blk_tvalid),
        .s_blk_tready  (s_blk_tready),
        .m_byte_tdata  (m_byte_tdata),
        .m_byte_tvalid (m_byte_tvalid),
        .m_byte_tready (m_byte_tready),
        .m_byte_tlast  (m_byte_tlast)
    );

endmodule

// File: doc/axis_block_bridge.md
Name: axis_block_bridge

Overview:
Parametrised byte-stream to block bridge between the UART AXI-Stream byte interface and the block-cipher AXI-Stream block interface. It replaces the fixed 8-byte counter-plus-width-adapter pair, and adds configurable block size, byte order, idle-timeout padding and a padded-block flag. The packer direction runs byte→block (UART RX→cipher). The serializer direction runs block→byte with tlast (cipher→UART TX).

Parameters:
BLOCK_BYTES, 8, bytes per cipher block; legal range 2..32.
MSB_FIRST, 1, 1: first byte maps to tdata[8*BLOCK_BYTES-1 -: 8]; 0: first byte maps to tdata[7:0]. Same mapping applies in both directions.
PAD_MODE, 0, 0: no padding (wait indefinitely); 1: zero pad on timeout; 2: pad value = number of pad bytes (PKCS#7 style).
TIMEOUT_CYCLES, 100000, idle cycles before a partial block is padded; 0 disables the timeout regardless of PAD_MODE.

Ports:
clk  in  1  single clock for all logic
rst  in  1  asynchronous reset, active-high
s_byte_tdata  in  8  UART RX byte
s_byte_tvalid  in  1  byte valid
s_byte_tready  out  1  byte accepted when tvalid&&tready
m_blk_tdata  out  8*BLOCK_BYTES  packed block to cipher
m_blk_tvalid  out  1  block valid
m_blk_tready  in  1  cipher ready
m_blk_tuser  out  1  1 = block contains pad bytes
s_blk_tdata  in  8*BLOCK_BYTES  block from cipher
s_blk_tvalid  in  1  block valid
s_blk_tready  out  1  serializer ready
m_byte_tdata  out  8  UART TX byte
m_byte_tvalid  out  1  byte valid
m_byte_tready  in  1  UART TX ready
m_byte_tlast  out  1  high on the last byte of each block
blk_count  out  16  blocks emitted on m_blk, wraps 0xFFFF→0
pad_pulse  out  1  one-cycle pulse on entry to PAD

Behaviour:
- Reset (async assert): all tvalid low, s_byte_tready=0, s_blk_tready=0, tuser=0, tlast=0, blk_count=0, pad_pulse=0. Packer enters FILL with idx=0; timer=0; serializer becomes empty. Partial blocks are discarded. First cycle after deassert: s_byte_tready=1, s_blk_tready=1.
- Packer FSM states: FILL, PAD, HOLD.
  - FILL: s_byte_tready=1. Each accepted byte is written to slot idx, then idx++. Accepting the byte at idx==BLOCK_BYTES-1 moves to HOLD with tuser=0.
  - Timer: counts only in FILL while idx!=0 and no byte is accepted. It clears on any accept.
  - Timeout: when timer reaches TIMEOUT_CYCLES-1 and PAD_MODE!=0 and TIMEOUT_CYCLES!=0, move to PAD and latch pad value: 0x00 for mode 1, BLOCK_BYTES-idx for mode 2.
  - Simultaneous accept and expiry in the same cycle: the accept wins and the timer clears.
  - PAD: s_byte_tready=0. One pad byte is written per cycle until the block is full, then move to HOLD with tuser=1.
  - HOLD: s_byte_tready=0, m_blk_tvalid=1. tdata and tuser are stable until the handshake. On m_blk_tready, blk_count++, idx=0, go to FILL.
  - Latency: m_blk_tvalid rises the cycle after the last byte is accepted. Peak throughput is BLOCK_BYTES+1 cycles per block.
- Serializer:
  - Empty state: s_blk_tready=1. Accepting a block loads the register and sets cnt=0. m_byte_tvalid=1 from the next cycle.
  - m_byte_tdata is the byte at slot cnt, using the MSB_FIRST mapping. cnt++ on each handshake.
  - m_byte_tlast = (cnt==BLOCK_BYTES-1).
  - s_blk_tready = empty || (tlast && m_byte_tready). This allows back-to-back blocks with no bubble.
  - m_byte_tvalid holds and tdata stays stable while m_byte_tready=0.
- Independence: the two directions share nothing except clk/rst.
- Counter widths: idx and cnt are $clog2(BLOCK_BYTES) bits. The timer is $clog2(TIMEOUT_CYCLES+1) bits.

Decomposition:
- Package axis_block_bridge_pkg holds:
  - pad_mode_e enum (PAD_NONE, PAD_ZERO, PAD_COUNT);
  - pack_state_e enum (FILL, PAD, HOLD);
  - localparam function for the byte-slot index (MSB_FIRST mapping), shared by both directions.
- One sub-module: block_serializer (block→byte with tlast). The packer FSM stays in the top module.

Test Plan:
- Send bytes 0x01..0x08, BLOCK_BYTES=8, MSB_FIRST=1 -> m_blk_tdata=0x0102030405060708, tuser=0, blk_count=1.
- MSB_FIRST=0, same bytes -> m_blk_tdata=0x0807060504030201. Feed that block to s_blk -> m_byte emits 0x01..0x08 with tlast only on 0x08.
- PAD_MODE=2, TIMEOUT_CYCLES=16, send 0xAA,0xBB,0xCC then idle -> pad_pulse after 16 idle cycles; block 0xAABBCC0505050505, tuser=1.
- PAD_MODE=1 with a byte arriving exactly on the expiry cycle -> no pad. Then idle -> zero pad; block 0xAABBCCDD00000000, tuser=1.
- Hold m_blk_tready=0 for 20 cycles while bytes are offered -> s_byte_tready=0, m_blk_tdata stable. Then release -> next 8 bytes form a new block.
- Back-to-back s_blk blocks with m_byte_tready=1 -> 16 contiguous bytes with no bubble. Assert rst mid-block -> all tvalid low immediately; the partial block is never emitted.
